// File: rtl/vga_pkg.sv
// Shared VGA 800x600 timing constants and vblank scheduler state encoding.
package vga_pkg;

    localparam int unsigned VER_TOT_TIME  = 628;
    localparam int unsigned VER_ADDR_TIME = 600;
    localparam int unsigned HOR_TOT_TIME  = 1056;

    typedef enum logic [1:0] {
        StActive,
        StWindow,
        StHold
    } sched_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational rotate-priority arbiter: first set request at or above ptr, wrapping.
module rr_arbiter #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned PTR_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N_REQ-1:0] gnt,
    output logic [PTR_W-1:0] idx,
    output logic             valid
);

    int j;

    // Walk from the farthest candidate back to ptr so the nearest hit wins last.
    always_comb begin
        gnt   = '0;
        idx   = '0;
        valid = 1'b0;
        j     = 0;
        for (int k = int'(N_REQ) - 1; k >= 0; k--) begin
            j = (int'(ptr) + k) % int'(N_REQ);
            if (req[j]) begin
                gnt    = '0;
                gnt[j] = 1'b1;
                idx    = PTR_W'(j);
                valid  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/vblank_scheduler.sv
// Round-robin sharing of the vertical blanking interval among update agents.
// Optional VBLANK_SCHED_STATS_EN adds the missed-frame counter output.
module vblank_scheduler
    import vga_pkg::*;
#(
    parameter int unsigned N_REQ       = 4,
    parameter int unsigned MAX_HOLD    = 64,
    parameter int unsigned GUARD_LINES = 2
) (
    input  logic             pclk,
    input  logic             rst_n,
    input  logic             vblnk,
    input  logic [10:0]      vcount,
    input  logic [N_REQ-1:0] req,
    input  logic [N_REQ-1:0] done,
    output logic [N_REQ-1:0] gnt,
    output logic             busy,
    output logic             frame_tick,
    output logic [15:0]      frame_cnt,
    output logic             overrun
`ifdef VBLANK_SCHED_STATS_EN
    ,
    output logic [7:0]       missed
`endif
);

    localparam int unsigned PTR_W = $clog2(N_REQ);
    localparam int unsigned CNT_W = $clog2(MAX_HOLD + 1);
    localparam logic [10:0] GRANT_LIMIT = 11'(VER_TOT_TIME - 1 - GUARD_LINES);

    sched_state_e     state;
    logic             vblnk_q;
    logic [N_REQ-1:0] served;
    logic [PTR_W-1:0] ptr;
    logic [PTR_W-1:0] gnt_idx;
    logic [CNT_W-1:0] hold_cnt;

    logic [N_REQ-1:0] eligible;
    logic [N_REQ-1:0] arb_gnt;
    logic [PTR_W-1:0] arb_idx;
    logic             arb_valid;
    logic             normal_end;
    logic             timeout;
    logic [PTR_W-1:0] next_ptr;

    assign eligible   = req & ~served;
    assign busy       = |gnt;
    // Done bits for other agents are ignored; a dropped request also ends normally.
    assign normal_end = (|(done & gnt)) | ~(|(req & gnt));
    assign timeout    = hold_cnt == CNT_W'(MAX_HOLD - 1);
    assign next_ptr   = (gnt_idx == PTR_W'(N_REQ - 1)) ? '0 : gnt_idx + 1'b1;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .PTR_W (PTR_W)
    ) u_arb (
        .req   (eligible),
        .ptr   (ptr),
        .gnt   (arb_gnt),
        .idx   (arb_idx),
        .valid (arb_valid)
    );

    // vblnk_q resets high so a vblnk already asserted at reset release is not an edge.
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= StActive;
            vblnk_q    <= 1'b1;
            served     <= '0;
            ptr        <= '0;
            gnt_idx    <= '0;
            hold_cnt   <= '0;
            gnt        <= '0;
            frame_tick <= 1'b0;
            frame_cnt  <= '0;
            overrun    <= 1'b0;
        end else begin
            vblnk_q    <= vblnk;
            frame_tick <= 1'b0;
            overrun    <= 1'b0;
            unique case (state)
                StActive: begin
                    if (vblnk && !vblnk_q) begin
                        frame_tick <= 1'b1;
                        frame_cnt  <= frame_cnt + 16'd1;
                        served     <= '0;
                        state      <= StWindow;
                    end
                end
                StWindow: begin
                    if (!vblnk) begin
                        state <= StActive;
                    end else if (arb_valid && (vcount < GRANT_LIMIT)) begin
                        gnt      <= arb_gnt;
                        gnt_idx  <= arb_idx;
                        hold_cnt <= '0;
                        state    <= StHold;
                    end
                end
                StHold: begin
                    hold_cnt <= hold_cnt + 1'b1;
                    if (normal_end || timeout || !vblnk) begin
                        gnt             <= '0;
                        served[gnt_idx] <= 1'b1;
                        ptr             <= next_ptr;
                        overrun         <= !normal_end;
                        state           <= vblnk ? StWindow : StActive;
                    end
                end
                default: state <= StActive;
            endcase
        end
    end

`ifdef VBLANK_SCHED_STATS_EN
    logic frame_end;

    // The agent whose grant is cut by the frame end has been served, not missed.
    assign frame_end = !vblnk && vblnk_q && (state != StActive);

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            missed <= '0;
        end else if (frame_end && (|(eligible & ~gnt)) && (missed != 8'hFF)) begin
            missed <= missed + 8'd1;
        end
    end
`endif

endmodule

// File: doc/vblank_scheduler.md
# vblank_scheduler

Round-robin scheduler that shares the vertical-blanking interval of the 800x600 VGA frame among up to N_REQ update agents (sprite movers, score logic, palette writers). It sits beside the VGA timing generator on the pixel clock, consumes its blanking and line count, and grants at most one agent at a time so that frame-visible state changes only while no pixels are drawn. It also emits a per-frame tick and frame counter for game logic.

## Interface
- N_REQ, 4, number of requesters (2..8)
- MAX_HOLD, 64, maximum grant length in pclk cycles
- GUARD_LINES, 2, lines before end of blanking in which no new grant starts
- pclk  in  1  pixel clock; all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- vblnk  in  1  vertical blanking from timing generator
- vcount  in  11  current line, 0..627
- req  in  N_REQ  per-agent request, level
- done  in  N_REQ  per-agent completion, one-cycle pulse while granted
- gnt  out  N_REQ  one-hot grant, registered
- busy  out  1  high while any grant active
- frame_tick  out  1  one-cycle pulse at start of blanking
- frame_cnt  out  16  frames since reset, wraps 65535->0
- overrun  out  1  one-cycle pulse when a grant is revoked forcibly

## Operation
- States: ACTIVE, WINDOW, HOLD.
- ACTIVE: gnt=0. Registered vblnk rising edge -> frame_tick=1 for one cycle, frame_cnt+1, served mask cleared, go to WINDOW.
- WINDOW: eligible = req & ~served. New grant allowed only when vcount < 627-GUARD_LINES. Pick first eligible index searching upward (wrapping) from ptr; load gnt one-hot, clear hold counter, go to HOLD. If vblnk low -> ACTIVE.
- HOLD: hold counter increments each cycle. Grant ends on: done[i] (normal); req[i] dropping (normal); counter reaching MAX_HOLD (overrun); vblnk falling (overrun). On end: gnt=0, served[i]=1, ptr=(i+1) mod N_REQ, return to WINDOW (or ACTIVE if vblnk low).
- Each agent is granted at most once per frame.
- Precedence in one cycle: done/req-drop beats timeout and vblnk fall (no overrun). Bits of done not matching the granted index are ignored.
- busy = |gnt.

## Timing
- Reset values: gnt=0, busy=0, frame_tick=0, frame_cnt=0, overrun=0, ptr=0, served=0, state ACTIVE.
- frame_tick is asserted on the cycle after the first cycle with vblnk=1.
- req sampled high in WINDOW at cycle t -> gnt high at t+1.
- End condition sampled at cycle t -> gnt low at t+1. gnt stays low for at least one cycle between grants.
- Timeout: a grant is held for at most MAX_HOLD cycles; overrun pulses on the cycle gnt drops.
- Reset mid-grant: gnt drops asynchronously. The first frame_tick after reset needs a fresh vblnk rising edge.

## Configuration
- VBLANK_SCHED_STATS_EN defined: adds output missed[7:0], which counts frames that end (vblnk falls) with eligible non-zero. It saturates at 255, resets to 0, and is updated the cycle after vblnk falls.
- Not defined: port and counter are absent. All other behaviour is identical.

## Structure
- Shared package vga_pkg: VER_TOT_TIME=628, VER_ADDR_TIME=600, HOR_TOT_TIME=1056, scheduler state enum.
- Sub-module rr_arbiter: combinational rotate-priority pick (req vector, ptr -> one-hot plus valid), parameterised by N_REQ.

## Test plan
- Reset with req=4'b1111, then run a full frame -> frame_tick once at blanking start, frame_cnt=1, grants in order 0,1,2,3, each ended by done, overrun never set.
- ptr=2 left from the previous frame, req=4'b1001 -> next frame grants 3 then 0.
- Agent 1 never pulses done -> gnt[1] drops after exactly 64 cycles, overrun pulses once, agent 2 granted 2 cycles later.
- Grant active when vblnk falls -> gnt=0 the next cycle with overrun=1. If done arrives in the same cycle, overrun=0.
- req[0] first rises at vcount=626 with GUARD_LINES=2 -> no grant this frame. It is granted in the next frame's window. With STATS_EN, missed=1.
- rst_n pulsed low mid-grant -> gnt=0 immediately, frame_cnt=0, and no grant until the next vblnk rising edge.
